// File: rtl/ghost_pkg.sv
// ghost_pkg: shared types and defaults for the ghost scheduler slice.
//   sched_state_t  scheduler FSM state encoding
//   dir_t          2-bit mover direction codes carried on random_dir
//   DEF_*          default frame timing constants (30 Hz frame rate)
//   lfsr_next      one step of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
package ghost_pkg;

    typedef enum logic [1:0] {
        IDLE_ST   = 2'd0,
        RUN_ST    = 2'd1,
        FRIGHT_ST = 2'd2,
        PAUSE_ST  = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int         DEF_NUM_GHOSTS      = 2;
    localparam int         DEF_FRAMES_PER_TURN = 150;
    localparam int         DEF_FRIGHT_FRAMES   = 180;
    localparam int         DEF_RESPAWN_FRAMES  = 60;
    localparam logic [7:0] DEF_LFSR_SEED       = 8'hA5;

    // x^8 + x^6 + x^5 + x^4 + 1 is maximal length, so a nonzero seed never reaches 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/ghost_respawn_timer.sv
// ghost_respawn_timer: per-ghost hold-off counter after the ghost is eaten.
//   clk, reset  clock, async active-high reset
//   clear       drop any pending hold-off (new game)
//   load        start a hold-off of RESPAWN_FRAMES frames (wins over tick)
//   tick        one frame elapsed; counter saturates at 0
//   busy        counter nonzero: the ghost is held stopped
module ghost_respawn_timer
    import ghost_pkg::*;
#(
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic tick,
    output logic busy
);

    localparam int CW = $clog2(RESPAWN_FRAMES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (load)
            cnt <= CW'(RESPAWN_FRAMES);
        else if (tick && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/ghost_scheduler.sv
// ghost_scheduler: game-level controller for all ghost movers.
//   clk, reset            clock, async active-high reset
//   startOfFrame          1-cycle frame pulse
//   game_start            level, leaves IDLE_ST
//   game_pause            level, freezes timers/LFSR/strobes while high
//   power_pellet          1-cycle pulse, enter or extend frightened mode
//   collision_pac_ghost   per-ghost collision level
//   ghost_reset           per-ghost 1-cycle respawn pulse
//   ghost_stop            per-ghost hold level
//   turn_strobe           per-ghost 1-cycle re-pick pulse
//   random_dir            2 bits per ghost, held between that ghost's strobes
//   frightened            high while in FRIGHT_ST
//   ghost_eaten, pac_dead 1-cycle score / death events
module ghost_scheduler
    import ghost_pkg::*;
#(
    parameter int         NUM_GHOSTS      = DEF_NUM_GHOSTS,
    parameter int         FRAMES_PER_TURN = DEF_FRAMES_PER_TURN,
    parameter int         FRIGHT_FRAMES   = DEF_FRIGHT_FRAMES,
    parameter int         RESPAWN_FRAMES  = DEF_RESPAWN_FRAMES,
    parameter logic [7:0] LFSR_SEED       = DEF_LFSR_SEED
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    game_start,
    input  logic                    game_pause,
    input  logic                    power_pellet,
    input  logic [NUM_GHOSTS-1:0]   collision_pac_ghost,
    output logic [NUM_GHOSTS-1:0]   ghost_reset,
    output logic [NUM_GHOSTS-1:0]   ghost_stop,
    output logic [NUM_GHOSTS-1:0]   turn_strobe,
    output logic [2*NUM_GHOSTS-1:0] random_dir,
    output logic                    frightened,
    output logic                    ghost_eaten,
    output logic                    pac_dead
);

    localparam int FW = $clog2(FRAMES_PER_TURN + 1);
    localparam int TW = $clog2(FRIGHT_FRAMES + 1);
    localparam int PW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

    sched_state_t          state, saved_state;
    logic [7:0]            lfsr;
    logic [FW-1:0]         frame_cnt;
    logic [TW-1:0]         fright_cnt;
    logic [NUM_GHOSTS-1:0] pending;
    logic [PW-1:0]         rr_ptr, round_idx;
    logic [NUM_GHOSTS-1:0] busy;

    logic                  active, run_hit, frame_tick, new_game;
    logic [NUM_GHOSTS-1:0] eat;

    assign active     = (state == RUN_ST) || (state == FRIGHT_ST);
    // A RUN collision ends the level, so that cycle does no frame bookkeeping.
    assign run_hit    = (state == RUN_ST) && (|collision_pac_ghost);
    assign frame_tick = startOfFrame && active && !game_pause && !run_hit;
    assign new_game   = (state == IDLE_ST) && game_start;
    // Ghosts already respawning cannot be eaten again.
    assign eat        = (state == FRIGHT_ST && !game_pause) ? (collision_pac_ghost & ~busy) : '0;

    assign frightened = (state == FRIGHT_ST);
    assign ghost_stop = active ? busy : '1;

    genvar g;
    generate
        for (g = 0; g < NUM_GHOSTS; g++) begin : gen_timer
            ghost_respawn_timer #(.RESPAWN_FRAMES(RESPAWN_FRAMES)) u_timer (
                .clk   (clk),
                .reset (reset),
                .clear (new_game),
                .load  (eat[g]),
                .tick  (frame_tick),
                .busy  (busy[g])
            );
        end
    endgenerate

    // Round-robin pick: rotate the eligible mask so rr_ptr sits at bit 0,
    // take the lowest set bit, then rotate the offset back.
    logic [NUM_GHOSTS-1:0]   eligible, rot;
    logic [2*NUM_GHOSTS-1:0] dbl;
    logic [PW:0]             sum;
    logic [PW-1:0]           off, grant_idx, next_ptr;
    logic                    grant_vld;
    logic [NUM_GHOSTS-1:0]   grant_oh;

    always_comb begin
        eligible  = pending & ~busy;
        dbl       = {eligible, eligible} >> rr_ptr;
        rot       = dbl[NUM_GHOSTS-1:0];
        grant_vld = 1'b0;
        off       = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_vld = 1'b1;
                off       = PW'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (PW+1)'(NUM_GHOSTS))
            sum = sum - (PW+1)'(NUM_GHOSTS);
        grant_idx = sum[PW-1:0];
        next_ptr  = (grant_idx == PW'(NUM_GHOSTS - 1)) ? '0 : grant_idx + 1'b1;
        grant_oh  = grant_vld ? (NUM_GHOSTS'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE_ST;
            saved_state <= IDLE_ST;
            lfsr        <= LFSR_SEED;
            frame_cnt   <= '0;
            fright_cnt  <= '0;
            pending     <= '0;
            rr_ptr      <= '0;
            round_idx   <= '0;
            ghost_reset <= '0;
            turn_strobe <= '0;
            random_dir  <= {NUM_GHOSTS{2'(DIR_UP)}};
            ghost_eaten <= 1'b0;
            pac_dead    <= 1'b0;
        end else begin
            ghost_reset <= '0;
            turn_strobe <= '0;
            ghost_eaten <= 1'b0;
            pac_dead    <= 1'b0;
            if (state != PAUSE_ST)
                lfsr <= lfsr_next(lfsr);

            case (state)
                IDLE_ST: begin
                    if (game_start) begin
                        state       <= RUN_ST;
                        ghost_reset <= '1;
                        frame_cnt   <= '0;
                        fright_cnt  <= '0;
                        pending     <= '0;
                        rr_ptr      <= '0;
                        round_idx   <= '0;
                    end
                end

                PAUSE_ST: begin
                    if (!game_pause)
                        state <= saved_state;
                end

                default: begin
                    if (game_pause) begin
                        saved_state <= state;
                        state       <= PAUSE_ST;
                    end else if (run_hit) begin
                        pac_dead    <= 1'b1;
                        ghost_reset <= '1;
                        state       <= IDLE_ST;
                    end else begin
                        if (state == RUN_ST) begin
                            if (power_pellet) begin
                                state      <= FRIGHT_ST;
                                fright_cnt <= TW'(FRIGHT_FRAMES);
                            end
                        end else begin
                            if (|eat) begin
                                ghost_reset <= eat;
                                ghost_eaten <= 1'b1;
                            end
                            if (power_pellet)
                                fright_cnt <= TW'(FRIGHT_FRAMES);
                            else if (startOfFrame) begin
                                if (fright_cnt <= TW'(1)) begin
                                    fright_cnt <= '0;
                                    state      <= RUN_ST;
                                end else
                                    fright_cnt <= fright_cnt - 1'b1;
                            end
                        end

                        // Turn rounds keep running through mode changes.
                        if (startOfFrame) begin
                            if (frame_cnt == FW'(FRAMES_PER_TURN - 1)) begin
                                frame_cnt <= '0;
                                pending   <= '1;
                                rr_ptr    <= round_idx;
                                round_idx <= (round_idx == PW'(NUM_GHOSTS - 1)) ? '0 : round_idx + 1'b1;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                                if (grant_vld) begin
                                    turn_strobe <= grant_oh;
                                    pending     <= pending & ~grant_oh;
                                    rr_ptr      <= next_ptr;
                                    for (int i = 0; i < NUM_GHOSTS; i++)
                                        if (grant_oh[i])
                                            random_dir[2*i +: 2] <= lfsr[1:0];
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_scheduler.sv
// tb_ghost_scheduler: directed bench for ghost_scheduler (2 ghosts, default timing).
module tb_ghost_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame, game_start, game_pause, power_pellet;
    logic [1:0] collision_pac_ghost;
    logic [1:0] ghost_reset, ghost_stop, turn_strobe;
    logic [3:0] random_dir;
    logic       frightened, ghost_eaten, pac_dead;

    ghost_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (startOfFrame),
        .game_start          (game_start),
        .game_pause          (game_pause),
        .power_pellet        (power_pellet),
        .collision_pac_ghost (collision_pac_ghost),
        .ghost_reset         (ghost_reset),
        .ghost_stop          (ghost_stop),
        .turn_strobe         (turn_strobe),
        .random_dir          (random_dir),
        .frightened          (frightened),
        .ghost_eaten         (ghost_eaten),
        .pac_dead            (pac_dead)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent LFSR reference: x^8+x^6+x^5+x^4+1, held while the DUT sits in pause
    // (pause state lags game_pause by one clock). m_prev is the value the DUT held
    // just before the most recent edge.
    logic [7:0] m_lfsr, m_prev;
    logic       m_pause;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr  <= 8'hA5;
            m_prev  <= 8'hA5;
            m_pause <= 1'b0;
        end else begin
            m_prev <= m_lfsr;
            if (!m_pause)
                m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_pause <= game_pause;
        end
    end

    int n_strobe = 0;
    always @(negedge clk) n_strobe = n_strobe + $countones(turn_strobe);

    logic [1:0] ts_q, ts_nxt;
    logic [7:0] lf_q;
    logic [1:0] rd0_q;
    int         s0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One frame = SOF cycle + 2 idle cycles. Captures strobe/LFSR right after SOF edge.
    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            ts_q = turn_strobe;
            lf_q = m_prev;
            tick();
            ts_nxt = turn_strobe;
            tick();
        end
    endtask

    task automatic start_game();
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        startOfFrame = 1'b0; game_start = 1'b0; game_pause = 1'b0;
        power_pellet = 1'b0; collision_pac_ghost = 2'b00;
        tick(); tick();
        chk("rst_stop", 32'(ghost_stop), 32'h3);
        chk("rst_pulses", {28'h0, ghost_reset, turn_strobe}, 32'h0);
        reset = 1'b0;
        tick();

        // 1: reset mid-FRIGHT with 90 frames left
        start_game();
        chk("start_greset", 32'(ghost_reset), 32'h3);
        power_pellet = 1'b1; tick(); power_pellet = 1'b0;
        frame(90);
        chk("t1_fright", 32'(frightened), 32'h1);
        reset = 1'b1;
        tick();
        chk("t1_stop", 32'(ghost_stop), 32'h3);
        chk("t1_fright_rst", 32'(frightened), 32'h0);
        chk("t1_pulses", {26'h0, ghost_reset, turn_strobe, ghost_eaten, pac_dead}, 32'h0);
        chk("t1_rdir", 32'(random_dir), 32'h0);
        reset = 1'b0;
        tick();

        // 2: turn rounds
        start_game();
        chk("t2_greset", 32'(ghost_reset), 32'h3);
        tick();
        chk("t2_greset_1cyc", 32'(ghost_reset), 32'h0);
        chk("t2_stop_run", 32'(ghost_stop), 32'h0);
        s0 = n_strobe;
        frame(150);
        chk("t2_no_strobe_r0", 32'(n_strobe - s0), 32'h0);
        frame(1);
        chk("t2_ts151", 32'(ts_q), 32'h1);
        chk("t2_ts151_1cyc", 32'(ts_nxt), 32'h0);
        chk("t2_rd0", 32'(random_dir[1:0]), 32'(lf_q[1:0]));
        rd0_q = lf_q[1:0];
        frame(1);
        chk("t2_ts152", 32'(ts_q), 32'h2);
        chk("t2_rd1", 32'(random_dir[3:2]), 32'(lf_q[1:0]));
        chk("t2_rd0_hold", 32'(random_dir[1:0]), 32'(rd0_q));
        s0 = n_strobe;
        frame(148);
        chk("t2_quiet", 32'(n_strobe - s0), 32'h0);
        frame(1);
        chk("t2_r2_first", 32'(ts_q), 32'h2);
        frame(1);
        chk("t2_r2_second", 32'(ts_q), 32'h1);

        // 3: collision in RUN
        collision_pac_ghost = 2'b10; tick(); collision_pac_ghost = 2'b00;
        chk("t3_pac_dead", 32'(pac_dead), 32'h1);
        chk("t3_greset", 32'(ghost_reset), 32'h3);
        tick();
        chk("t3_pulses_off", {29'h0, ghost_reset, pac_dead}, 32'h0);
        chk("t3_idle_stop", 32'(ghost_stop), 32'h3);

        // 4: eat ghost 0 in FRIGHT
        start_game();
        power_pellet = 1'b1; tick(); power_pellet = 1'b0;
        chk("t4_fright", 32'(frightened), 32'h1);
        frame(10);
        collision_pac_ghost = 2'b01; tick(); collision_pac_ghost = 2'b00;
        chk("t4_eaten", 32'(ghost_eaten), 32'h1);
        chk("t4_greset", 32'(ghost_reset), 32'h1);
        chk("t4_no_death", 32'(pac_dead), 32'h0);
        chk("t4_stop", 32'(ghost_stop), 32'h1);
        tick();
        chk("t4_eaten_1cyc", 32'(ghost_eaten), 32'h0);
        frame(30);
        collision_pac_ghost = 2'b01; tick(); collision_pac_ghost = 2'b00;
        chk("t4_repeat_ign", {29'h0, ghost_reset, ghost_eaten}, 32'h0);
        frame(29);
        chk("t4_stop59", 32'(ghost_stop), 32'h1);
        frame(1);
        chk("t4_stop60", 32'(ghost_stop), 32'h0);
        frame(109);
        chk("t4_fright179", 32'(frightened), 32'h1);
        frame(1);
        chk("t4_fright180", 32'(frightened), 32'h0);

        // 5: pellet extension
        power_pellet = 1'b1; tick(); power_pellet = 1'b0;
        frame(100);
        power_pellet = 1'b1; tick(); power_pellet = 1'b0;
        frame(179);
        chk("t5_fright279", 32'(frightened), 32'h1);
        frame(1);
        chk("t5_fright280", 32'(frightened), 32'h0);

        // 6: pause mid-round
        collision_pac_ghost = 2'b01; tick(); collision_pac_ghost = 2'b00;
        chk("t6_pac_dead", 32'(pac_dead), 32'h1);
        tick();
        start_game();
        frame(100);
        game_pause = 1'b1; tick();
        chk("t6_pause_stop", 32'(ghost_stop), 32'h3);
        s0 = n_strobe;
        frame(40);
        game_pause = 1'b0; tick();
        chk("t6_resume_stop", 32'(ghost_stop), 32'h0);
        frame(50);
        chk("t6_no_strobe", 32'(n_strobe - s0), 32'h0);
        frame(1);
        chk("t6_ts_shifted", 32'(ts_q), 32'h1);
        chk("t6_rd0", 32'(random_dir[1:0]), 32'(lf_q[1:0]));
        frame(1);
        chk("t6_ts2", 32'(ts_q), 32'h2);
        chk("t6_rd1", 32'(random_dir[3:2]), 32'(lf_q[1:0]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
